// File: rtl/current_off_axil_regs.sv
// current_off_axil_regs: AXI4-Lite register slave for one current turn-off channel.
// Holds CTRL/DEBOUNCE/OFF_TIME/SCRATCH, runs the trip FSM, reports STATUS/TRIP_COUNT.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET  clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*           write address/data/response channels
//   S_AXI_AR*/R*              read address/data channels
//   over_i                    over-current flag (synchronous)
//   switch_off_o              forces the power switch off
//   trip_irq_o                one-cycle pulse on each trip (when irq_en)
module current_off_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              over_i,
    output logic                              switch_off_o,
    output logic                              trip_irq_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEB  = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    logic        aw_rdy;
    logic        ar_rdy;
    logic        b_valid;
    logic        r_valid;
    logic [1:0]  b_resp;
    logic [1:0]  r_resp;
    logic [31:0] r_data;

    logic [31:0] ctrl;
    logic [31:0] debounce;
    logic [31:0] off_time;
    logic [31:0] scratch;
    logic [31:0] trip_count;
    logic [31:0] cnt;
    state_t      state;
    logic        sw_off;
    logic        irq;

    logic [2:0]  wr_idx;
    logic [2:0]  rd_idx;
    logic        wr_go;
    logic        rd_go;
    logic [31:0] rd_data;
    logic        rd_err;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx = S_AXI_AWADDR[4:2];
    assign rd_idx = S_AXI_ARADDR[4:2];
    assign wr_go  = aw_rdy && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_go  = ar_rdy && S_AXI_ARVALID;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  s
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Write channel. A response being consumed this cycle frees the
    // slot, so back-to-back writes can land every second cycle.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_rdy  <= 1'b0;
            b_valid <= 1'b0;
            b_resp  <= RESP_OKAY;
        end else begin
            aw_rdy <= !aw_rdy && S_AXI_AWVALID && S_AXI_WVALID
                      && (!b_valid || S_AXI_BREADY);
            if (wr_go) begin
                b_valid <= 1'b1;
                b_resp  <= wr_idx[2] ? RESP_SLVERR : RESP_OKAY;
            end else if (b_valid && S_AXI_BREADY) begin
                b_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ctrl     <= '0;
            debounce <= '0;
            off_time <= '0;
            scratch  <= '0;
        end else if (wr_go) begin
            case (wr_idx)
                3'd0:    ctrl     <= merge(ctrl, S_AXI_WDATA, S_AXI_WSTRB);
                3'd1:    debounce <= merge(debounce, S_AXI_WDATA, S_AXI_WSTRB);
                3'd2:    off_time <= merge(off_time, S_AXI_WDATA, S_AXI_WSTRB);
                3'd3:    scratch  <= merge(scratch, S_AXI_WDATA, S_AXI_WSTRB);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        unique case (rd_idx)
            3'd0: rd_data = ctrl;
            3'd1: rd_data = debounce;
            3'd2: rd_data = off_time;
            3'd3: rd_data = scratch;
            3'd4: rd_data = {29'd0, over_i, state};
            3'd5: rd_data = trip_count;
            3'd6: rd_err  = 1'b1;
            3'd7: rd_err  = 1'b1;
        endcase
    end

    // Read channel: data is captured at the address handshake and held
    // until the master takes it.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ar_rdy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
        end else begin
            ar_rdy <= !ar_rdy && S_AXI_ARVALID && !r_valid;
            if (rd_go) begin
                r_valid <= 1'b1;
                r_data  <= rd_data;
                r_resp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_valid && S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Trip FSM. cnt counts debounce cycles in S_DEB and off cycles in S_OFF.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sw_off     <= 1'b0;
            irq        <= 1'b0;
            trip_count <= '0;
        end else begin
            irq <= 1'b0;
            if (!ctrl[0]) begin
                state  <= S_IDLE;
                cnt    <= '0;
                sw_off <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (over_i) begin
                            state <= S_DEB;
                            cnt   <= '0;
                        end
                    end
                    S_DEB: begin
                        if (!over_i) begin
                            state <= S_IDLE;
                        end else if (cnt >= debounce) begin
                            state  <= S_OFF;
                            cnt    <= '0;
                            sw_off <= 1'b1;
                            irq    <= ctrl[1];
                            if (trip_count != 32'hFFFF_FFFF)
                                trip_count <= trip_count + 32'd1;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    S_OFF: begin
                        // OFF_TIME of 0 latches off until enable drops.
                        if (off_time != '0 && cnt == off_time - 32'd1) begin
                            state  <= S_IDLE;
                            cnt    <= '0;
                            sw_off <= 1'b0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        cnt    <= '0;
                        sw_off <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign S_AXI_AWREADY = aw_rdy;
    assign S_AXI_WREADY  = aw_rdy;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;
    assign S_AXI_ARREADY = ar_rdy;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = r_resp;
    assign switch_off_o  = sw_off;
    assign trip_irq_o    = irq;

endmodule

// File: tb/tb_current_off_axil_regs.sv
// tb_current_off_axil_regs: bench for the current turn-off AXI4-Lite slave.
// Drives on negedge, samples on negedge, compares against a bench-side model.
module tb_current_off_axil_regs;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        over;
    logic        sw_off;
    logic        irq;

    int total = 0;
    int passed = 0;

    logic [31:0] m_regs [4];
    int unsigned m_trips;

    current_off_axil_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .over_i        (over),
        .switch_off_o  (sw_off),
        .trip_irq_o    (irq)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        if (a[4:2] < 3'd4) m_regs[a[4:2]] = byte_merge(m_regs[a[4:2]], d, s);
    endtask

    task automatic do_reset;
        @(negedge clk);
        areset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0;
        wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        over = 1'b0;
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_trips = 0;
    endtask

    // lat = cycles from the ready cycle to BVALID (-1 if never seen).
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp,
                             output int lat, output logic wr_both);
        int n;
        logic bv0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (!awready) begin
            total++;
            $display("FAIL aw_timeout: awready=%b want 1", awready);
            awvalid = 1'b0; wvalid = 1'b0;
            resp = 2'bxx; lat = -1; wr_both = 1'b0;
            return;
        end
        wr_both = wready;
        bv0 = bvalid;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 1;
        while (!bvalid && n < 32) begin
            @(negedge clk);
            n++;
        end
        lat = bv0 ? 0 : (bvalid ? n : -1);
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output int lat);
        int n;
        logic rv0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (!arready) begin
            total++;
            $display("FAIL ar_timeout: arready=%b want 1", arready);
            arvalid = 1'b0;
            d = 'x; resp = 2'bxx; lat = -1;
            return;
        end
        rv0 = rvalid;
        @(negedge clk);
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 32) begin
            @(negedge clk);
            n++;
        end
        lat = rv0 ? 0 : (rvalid ? n : -1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] deb, input logic [31:0] ot,
                       input logic [31:0] c);
        logic [1:0] r;
        int l;
        logic wb;
        axi_write(5'h04, deb, 4'hF, r, l, wb); model_write(5'h04, deb, 4'hF);
        axi_write(5'h08, ot, 4'hF, r, l, wb);  model_write(5'h08, ot, 4'hF);
        axi_write(5'h00, c, 4'hF, r, l, wb);   model_write(5'h00, c, 4'hF);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0] r;
        int l;
        do_reset();
        @(negedge clk);
        total++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp,
             rdata, sw_off, irq} !== '0)
            $display("FAIL reset_outputs: got aw%b w%b ar%b b%b r%b bresp%h rresp%h rdata%h sw%b irq%b want all 0",
                     awready, wready, arready, bvalid, rvalid, bresp,
                     rresp, rdata, sw_off, irq);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            axi_read(5'(i * 4), d, r, l);
            total++;
            if (d !== 32'h0 || r !== 2'b00)
                $display("FAIL reset_reg%0d: got %h/%b want 0/00", i, d, r);
            else passed++;
        end
    endtask

    task automatic test_rw_basic;
        logic [31:0] d;
        logic [1:0] r;
        int l;
        logic wb;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, r, l, wb);
            model_write(5'(i * 4), 32'(i + 1), 4'hF);
            total++;
            if (r !== 2'b00 || l != 1 || wb !== 1'b1)
                $display("FAIL basic_wr%0d: got resp %b lat %0d wready %b want 00 1 1",
                         i, r, l, wb);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), d, r, l);
            total++;
            if (d !== m_regs[i] || r !== 2'b00 || l != 1)
                $display("FAIL basic_rd%0d: got %h/%b lat %0d want %h/00 lat 1",
                         i, d, r, l, m_regs[i]);
            else passed++;
        end
    endtask

    task automatic test_strobe;
        logic [31:0] d;
        logic [1:0] r;
        int l;
        logic wb;
        axi_write(5'h0C, 32'h0, 4'hF, r, l, wb);
        model_write(5'h0C, 32'h0, 4'hF);
        axi_write(5'h0C, 32'hAABBCCDD, 4'b0101, r, l, wb);
        model_write(5'h0C, 32'hAABBCCDD, 4'b0101);
        axi_read(5'h0C, d, r, l);
        total++;
        if (d !== 32'h00BB00DD)
            $display("FAIL strobe: got %h want 00bb00dd", d);
        else passed++;
    endtask

    task automatic test_slverr;
        logic [31:0] d;
        logic [31:0] st0;
        logic [1:0] r;
        int l;
        logic wb;
        axi_read(5'h10, st0, r, l);
        for (int i = 4; i < 8; i++) begin
            axi_write(5'(i * 4), $urandom, 4'hF, r, l, wb);
            total++;
            if (r !== 2'b10)
                $display("FAIL slverr_wr%0d: got %b want 10", i, r);
            else passed++;
        end
        for (int i = 6; i < 8; i++) begin
            axi_read(5'(i * 4), d, r, l);
            total++;
            if (d !== 32'h0 || r !== 2'b10)
                $display("FAIL slverr_rd%0d: got %h/%b want 0/10", i, d, r);
            else passed++;
        end
        axi_read(5'h10, d, r, l);
        total++;
        if (d !== st0 || r !== 2'b00)
            $display("FAIL status_unchanged: got %h/%b want %h/00", d, r, st0);
        else passed++;
        axi_read(5'h14, d, r, l);
        total++;
        if (d !== 32'(m_trips))
            $display("FAIL tripcnt_ro: got %h want %h", d, m_trips);
        else passed++;
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic [31:0] v;
        logic [31:0] exp;
        logic [1:0] r;
        logic [1:0] er;
        logic [4:0] a;
        logic [3:0] s;
        int l;
        logic wb;
        for (int it = 0; it < 24; it++) begin
            a = 5'($urandom);
            v = $urandom;
            s = 4'($urandom);
            axi_write(a, v, s, r, l, wb);
            model_write(a, v, s);
            er = (a[4:2] < 3'd4) ? 2'b00 : 2'b10;
            total++;
            if (r !== er)
                $display("FAIL rand_wr%0d: addr %h got %b want %b", it, a, r, er);
            else passed++;
            a = 5'($urandom);
            axi_read(a, d, r, l);
            if (a[4:2] < 3'd4) exp = m_regs[a[4:2]];
            else if (a[4:2] == 3'd5) exp = 32'(m_trips);
            else exp = 32'h0;
            er = (a[4:2] >= 3'd6) ? 2'b10 : 2'b00;
            total++;
            if (d !== exp || r !== er)
                $display("FAIL rand_rd%0d: addr %h got %h/%b want %h/%b",
                         it, a, d, r, exp, er);
            else passed++;
        end
        axi_write(5'h00, 32'h0, 4'hF, r, l, wb);
        model_write(5'h00, 32'h0, 4'hF);
    endtask

    task automatic test_same_cycle;
        logic [31:0] oldv;
        logic [31:0] newv;
        logic [31:0] d;
        logic [1:0] r;
        int n;
        int l;
        oldv = m_regs[3];
        newv = $urandom;
        @(negedge clk);
        awaddr = 5'h0C; wdata = newv; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h0C; arvalid = 1'b1;
        n = 0;
        while (!(awready && arready) && n < 32) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        total++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== oldv)
            $display("FAIL same_cycle: got rv%b bv%b rdata %h want 1 1 %h",
                     rvalid, bvalid, rdata, oldv);
        else passed++;
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        model_write(5'h0C, newv, 4'hF);
        axi_read(5'h0C, d, r, l);
        total++;
        if (d !== newv)
            $display("FAIL same_cycle_new: got %h want %h", d, newv);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d;
        logic [1:0] r;
        int n;
        int l;
        d1 = $urandom;
        d2 = $urandom;
        @(negedge clk);
        bready = 1'b1;
        awaddr = 5'h0C; wdata = d1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 32) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        awaddr = 5'h04; wdata = d2;
        n = 1;
        while (!awready && n < 32) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 2)
            $display("FAIL b2b_spacing: got %0d cycles want 2", n);
        else passed++;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (bvalid !== 1'b1)
            $display("FAIL b2b_bvalid: got %b want 1", bvalid);
        else passed++;
        @(negedge clk);
        bready = 1'b0;
        total++;
        if (bvalid !== 1'b0)
            $display("FAIL b2b_bdone: got %b want 0", bvalid);
        else passed++;
        model_write(5'h0C, d1, 4'hF);
        model_write(5'h04, d2, 4'hF);
        axi_read(5'h0C, d, r, l);
        total++;
        if (d !== m_regs[3])
            $display("FAIL b2b_rd1: got %h want %h", d, m_regs[3]);
        else passed++;
        axi_read(5'h04, d, r, l);
        total++;
        if (d !== m_regs[1])
            $display("FAIL b2b_rd2: got %h want %h", d, m_regs[1]);
        else passed++;
    endtask

    // With over_i held high from edge 1, the trip lands on edge deb+2
    // and the switch stays off for ot cycles.
    task automatic test_trip(input int deb, input int ot);
        logic [31:0] d;
        logic [1:0] r;
        int l;
        logic e_sw;
        logic e_irq;
        cfg(32'(deb), 32'(ot), 32'h3);
        @(negedge clk);
        over = 1'b1;
        for (int k = 1; k <= deb + ot + 3; k++) begin
            @(negedge clk);
            e_sw = (k >= deb + 2) && (k < deb + 2 + ot);
            e_irq = (k == deb + 2);
            total++;
            if (sw_off !== e_sw || irq !== e_irq)
                $display("FAIL trip_d%0d_t%0d_k%0d: got sw %b irq %b want %b %b",
                         deb, ot, k, sw_off, irq, e_sw, e_irq);
            else passed++;
            if (k == deb + 2) over = 1'b0;
        end
        m_trips++;
        axi_read(5'h14, d, r, l);
        total++;
        if (d !== 32'(m_trips))
            $display("FAIL trip_count: got %0d want %0d", d, m_trips);
        else passed++;
        axi_read(5'h10, d, r, l);
        total++;
        if (d !== 32'h0)
            $display("FAIL trip_status: got %h want 0", d);
        else passed++;
    endtask

    task automatic test_no_trip;
        logic [31:0] d;
        logic [1:0] r;
        int l;
        int bad;
        cfg(32'd3, 32'd10, 32'h3);
        @(negedge clk);
        over = 1'b1;
        repeat (3) @(negedge clk);
        over = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sw_off !== 1'b0 || irq !== 1'b0) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL no_trip: got %0d cycles with sw/irq high want 0", bad);
        else passed++;
        axi_read(5'h10, d, r, l);
        total++;
        if (d !== 32'h0)
            $display("FAIL no_trip_status: got %h want 0", d);
        else passed++;
        axi_read(5'h14, d, r, l);
        total++;
        if (d !== 32'(m_trips))
            $display("FAIL no_trip_count: got %0d want %0d", d, m_trips);
        else passed++;
        cfg(32'd100, 32'd10, 32'h3);
        @(negedge clk);
        over = 1'b1;
        repeat (2) @(negedge clk);
        axi_read(5'h10, d, r, l);
        total++;
        if (d !== 32'h5)
            $display("FAIL deb_status: got %h want 5", d);
        else passed++;
        over = 1'b0;
        axi_read(5'h10, d, r, l);
        total++;
        if (d !== 32'h0)
            $display("FAIL deb_exit_status: got %h want 0", d);
        else passed++;
    endtask

    task automatic test_latched;
        logic [31:0] d;
        logic [1:0] r;
        int l;
        int deb;
        int n;
        int irqs;
        deb = int'($urandom_range(0, 4));
        cfg(32'(deb), 32'd0, 32'h1);
        @(negedge clk);
        over = 1'b1;
        irqs = 0;
        for (int k = 1; k <= deb + 2; k++) begin
            @(negedge clk);
            if (irq !== 1'b0) irqs++;
        end
        over = 1'b0;
        m_trips++;
        repeat (20) begin
            @(negedge clk);
            if (irq !== 1'b0) irqs++;
        end
        total++;
        if (irqs != 0)
            $display("FAIL latch_irq_masked: got %0d pulses want 0", irqs);
        else passed++;
        total++;
        if (sw_off !== 1'b1)
            $display("FAIL latch_hold: got %b want 1", sw_off);
        else passed++;
        axi_read(5'h10, d, r, l);
        total++;
        if (d !== 32'h2)
            $display("FAIL latch_status: got %h want 2", d);
        else passed++;
        @(negedge clk);
        awaddr = 5'h00; wdata = 32'h0; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 32) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sw_off !== 1'b1)
            $display("FAIL latch_at_accept: got %b want 1", sw_off);
        else passed++;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (sw_off !== 1'b1)
            $display("FAIL latch_after_write: got %b want 1", sw_off);
        else passed++;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        total++;
        if (sw_off !== 1'b0)
            $display("FAIL latch_release: got %b want 0", sw_off);
        else passed++;
        model_write(5'h00, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic [1:0] r;
        int n;
        int l;
        @(negedge clk);
        awaddr = 5'h0C; wdata = $urandom; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 32) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (bvalid !== 1'b1)
            $display("FAIL rst_mid_pending: got %b want 1", bvalid);
        else passed++;
        areset = 1'b1;
        @(negedge clk);
        total++;
        if (bvalid !== 1'b0 || awready !== 1'b0 || rvalid !== 1'b0)
            $display("FAIL rst_mid_drop: got bv%b aw%b rv%b want 0 0 0",
                     bvalid, awready, rvalid);
        else passed++;
        areset = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_trips = 0;
        axi_read(5'h14, d, r, l);
        total++;
        if (d !== 32'(m_trips))
            $display("FAIL rst_mid_trips: got %0d want %0d", d, m_trips);
        else passed++;
        axi_read(5'h0C, d, r, l);
        total++;
        if (d !== m_regs[3])
            $display("FAIL rst_mid_scratch: got %h want %h", d, m_regs[3]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rw_basic();
        test_strobe();
        test_slverr();
        test_random();
        test_same_cycle();
        test_back_to_back();
        test_trip(3, 10);
        repeat (3) test_trip(int'($urandom_range(0, 6)),
                             int'($urandom_range(1, 8)));
        test_no_trip();
        test_latched();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
